// File: rtl/data_upload_pkg.sv
// Shared definitions for the ioctl upload path: UIO command codes and fetch FSM encoding.
// The command codes are common with the download receiver.
package data_upload_pkg;

    localparam logic [7:0] UIO_CMD_FILE_TX     = 8'h53;
    localparam logic [7:0] UIO_CMD_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] UIO_CMD_FILE_INDEX  = 8'h55;
    localparam logic [7:0] UIO_CMD_FILE_RX     = 8'h56;
    localparam logic [7:0] UIO_CMD_FILE_RX_DAT = 8'h57;

    // Wide enough to hold RD_LAT-1 for RD_LAT up to 32.
    localparam int LAT_W = 5;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronisers for the SPI pins plus sck edge detection, all in the local clock.
// ss resets to the deselected level so nothing is decoded until the pin is really sampled.
module spi_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic ss,
    input  logic sdi,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_s,
    output logic sdi_s
);

    logic [1:0] sck_q, sck_d;
    logic [1:0] ss_q, ss_d;
    logic [1:0] sdi_q, sdi_d;

    always_comb begin
        sck_d = {sck_q[0], sck};
        ss_d  = {ss_q[0], ss};
        sdi_d = {sdi_q[0], sdi};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q <= 2'b00;
            ss_q  <= 2'b11;
            sdi_q <= 2'b00;
        end else begin
            sck_q <= sck_d;
            ss_q  <= ss_d;
            sdi_q <= sdi_d;
        end
    end

    assign sck_rise = sck_q[0] & ~sck_q[1];
    assign sck_fall = ~sck_q[0] & sck_q[1];
    assign ss_s     = ss_q[1];
    assign sdi_s    = sdi_q[1];

endmodule

// File: rtl/data_upload.sv
// SPI mode-0 slave that streams a memory region back to the io controller.
// Bytes are prefetched through a fixed-latency ioctl read port and shifted out MSB first.
module data_upload
    import data_upload_pkg::*;
#(
    parameter int         aw              = 22,
    parameter int         RD_LAT          = 2,
    parameter logic [7:0] UIO_FILE_RX     = UIO_CMD_FILE_RX,
    parameter logic [7:0] UIO_FILE_RX_DAT = UIO_CMD_FILE_RX_DAT
) (
    input  logic          clk_sdram,
    input  logic          rst,
    input  logic          sck,
    input  logic          ss,
    input  logic          sdi,
    output logic          sdo,
    output logic          sdo_en,
    output logic          uploading,
    output logic [aw-1:0] ioctl_addr,
    output logic          ioctl_rd,
    input  logic [7:0]    ioctl_din,
    output logic          underrun
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

    logic sck_rise, sck_fall, ss_s, sdi_s;

    spi_edge_sync u_sync (
        .clk      (clk_sdram),
        .rst      (rst),
        .sck      (sck),
        .ss       (ss),
        .sdi      (sdi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ss_s     (ss_s),
        .sdi_s    (sdi_s)
    );

    logic [3:0]       cnt_q, cnt_d;
    logic [6:0]       rx_q, rx_d;
    logic [7:0]       cmd_q, cmd_d;
    logic             uploading_q, uploading_d;
    logic [aw-1:0]    addr_q, addr_d;
    logic             rd_q, rd_d;
    logic             underrun_q, underrun_d;
    logic [7:0]       buf_q, buf_d;
    logic             buf_valid_q, buf_valid_d;
    logic [7:0]       tx_q, tx_d;
    logic             bnd_q, bnd_d;
    fetch_state_e     state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;

    logic       active;
    logic       fetch_start, fetch_abort, fetch_done;
    logic       buf_valid_eff;
    logic [7:0] buf_eff;

    always_comb begin
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        cmd_d       = cmd_q;
        uploading_d = uploading_q;
        addr_d      = addr_q;
        underrun_d  = underrun_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        tx_d        = tx_q;
        bnd_d       = bnd_q;
        fetch_start = 1'b0;
        fetch_abort = 1'b0;

        active = ~ss_s & (cmd_q == UIO_FILE_RX_DAT) & uploading_q;

        // A restart in the same cycle supersedes the completing fetch.
        fetch_done    = (state_q == FETCH_WAIT) && (lat_q == '0) && !rd_q;
        buf_valid_eff = buf_valid_q | fetch_done;
        buf_eff       = fetch_done ? ioctl_din : buf_q;
        if (fetch_done) begin
            buf_d       = ioctl_din;
            buf_valid_d = 1'b1;
        end

        if (ss_s) begin
            cnt_d = 4'd0;
            bnd_d = 1'b0;
        end else if (sck_rise) begin
            rx_d  = {rx_q[5:0], sdi_s};
            cnt_d = (cnt_q == 4'd15) ? 4'd8 : cnt_q + 4'd1;
            bnd_d = (cnt_q == 4'd7) || (cnt_q == 4'd15);
            if (cnt_q == 4'd7) begin
                cmd_d = {rx_q, sdi_s};
            end
            if ((cnt_q == 4'd15) && (cmd_q == UIO_FILE_RX)) begin
                if (sdi_s) begin
                    uploading_d = 1'b1;
                    addr_d      = '0;
                    underrun_d  = 1'b0;
                    buf_valid_d = 1'b0;
                    fetch_start = 1'b1;
                end else begin
                    uploading_d = 1'b0;
                    fetch_abort = 1'b1;
                end
            end
        end else if (sck_fall) begin
            bnd_d = 1'b0;
            if (active) begin
                if (bnd_q) begin
                    // buf holds the byte at addr_q; consume it and prefetch the next one.
                    tx_d        = buf_valid_eff ? buf_eff : 8'hFF;
                    underrun_d  = underrun_q | ~buf_valid_eff;
                    buf_valid_d = 1'b0;
                    addr_d      = addr_q + aw'(1);
                    fetch_start = 1'b1;
                end else begin
                    tx_d = {tx_q[6:0], 1'b0};
                end
            end
        end

        rd_d = fetch_start;
    end

    // Fetch FSM: the registered read strobe launches the latency countdown.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        if (fetch_abort) begin
            state_d = FETCH_IDLE;
        end else if (rd_q) begin
            state_d = FETCH_WAIT;
            lat_d   = LAT_INIT;
        end else if (state_q == FETCH_WAIT) begin
            if (lat_q == '0) begin
                state_d = FETCH_IDLE;
            end else begin
                lat_d = lat_q - LAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_sdram) begin
        if (rst) begin
            cnt_q       <= 4'd0;
            rx_q        <= 7'd0;
            cmd_q       <= 8'd0;
            uploading_q <= 1'b0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            underrun_q  <= 1'b0;
            buf_q       <= 8'd0;
            buf_valid_q <= 1'b0;
            tx_q        <= 8'd0;
            bnd_q       <= 1'b0;
            state_q     <= FETCH_IDLE;
            lat_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            cmd_q       <= cmd_d;
            uploading_q <= uploading_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            underrun_q  <= underrun_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            tx_q        <= tx_d;
            bnd_q       <= bnd_d;
            state_q     <= state_d;
            lat_q       <= lat_d;
        end
    end

    assign sdo        = active ? tx_q[7] : 1'b1;
    assign sdo_en     = active;
    assign uploading  = uploading_q;
    assign ioctl_addr = addr_q;
    assign ioctl_rd   = rd_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_data_upload.sv
// Directed bench for data_upload: three instances share the SPI pins (normal, slow memory,
// 4-bit address); each has its own memory model returning mem[i] = i ^ 8'hA5.
module tb_data_upload;

    logic clk = 1'b0;
    logic rst, sck, ss, sdi;

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Instance m: aw=22, RD_LAT=2
    logic        m_sdo, m_sdo_en, m_up, m_rd, m_underrun;
    logic [21:0] m_addr;
    logic [7:0]  m_din;
    // Instance s: aw=22, RD_LAT=32
    logic        s_sdo, s_sdo_en, s_up, s_rd, s_underrun;
    logic [21:0] s_addr;
    logic [7:0]  s_din;
    // Instance w: aw=4, RD_LAT=2
    logic        w_sdo, w_sdo_en, w_up, w_rd, w_underrun;
    logic [3:0]  w_addr;
    logic [7:0]  w_din;

    data_upload #(.aw(22), .RD_LAT(2)) u_m (
        .clk_sdram(clk), .rst(rst), .sck(sck), .ss(ss), .sdi(sdi),
        .sdo(m_sdo), .sdo_en(m_sdo_en), .uploading(m_up), .ioctl_addr(m_addr),
        .ioctl_rd(m_rd), .ioctl_din(m_din), .underrun(m_underrun));

    data_upload #(.aw(22), .RD_LAT(32)) u_s (
        .clk_sdram(clk), .rst(rst), .sck(sck), .ss(ss), .sdi(sdi),
        .sdo(s_sdo), .sdo_en(s_sdo_en), .uploading(s_up), .ioctl_addr(s_addr),
        .ioctl_rd(s_rd), .ioctl_din(s_din), .underrun(s_underrun));

    data_upload #(.aw(4), .RD_LAT(2)) u_w (
        .clk_sdram(clk), .rst(rst), .sck(sck), .ss(ss), .sdi(sdi),
        .sdo(w_sdo), .sdo_en(w_sdo_en), .uploading(w_up), .ioctl_addr(w_addr),
        .ioctl_rd(w_rd), .ioctl_din(w_din), .underrun(w_underrun));

    // Memory models: data for a read appears exactly RD_LAT cycles after the strobe cycle.
    logic [22:0] m_pipe[2];
    logic [22:0] s_pipe[32];
    logic [4:0]  w_pipe[2];

    always @(posedge clk) begin
        m_pipe[0] <= {m_rd, m_addr};
        m_pipe[1] <= m_pipe[0];
        s_pipe[0] <= {s_rd, s_addr};
        for (int i = 1; i < 32; i++) s_pipe[i] <= s_pipe[i-1];
        w_pipe[0] <= {w_rd, w_addr};
        w_pipe[1] <= w_pipe[0];
    end

    assign m_din = m_pipe[1][22]  ? (m_pipe[1][7:0] ^ 8'hA5)  : 8'h00;
    assign s_din = s_pipe[31][22] ? (s_pipe[31][7:0] ^ 8'hA5) : 8'h00;
    assign w_din = w_pipe[1][4]   ? ({4'h0, w_pipe[1][3:0]} ^ 8'hA5) : 8'h00;

    // Read-strobe and address-wrap monitors.
    int          m_rd_total = 0;
    logic [21:0] m_last_rd_addr = '0;
    logic [3:0]  w_prev_addr = '0;
    logic        w_wrap_seen = 1'b0;

    always @(posedge clk) begin
        if (m_rd) begin
            m_rd_total     <= m_rd_total + 1;
            m_last_rd_addr <= m_addr;
        end
        w_prev_addr <= w_addr;
        if (rst) w_wrap_seen <= 1'b0;
        else if (w_prev_addr == 4'hF && w_addr == 4'h0) w_wrap_seen <= 1'b1;
    end

    function automatic logic [7:0] mem_byte(input int i);
        logic [7:0] a;
        a = i[7:0];
        return a ^ 8'hA5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Shift nbits of val MSB first; sdo of each instance is captured just before each rise.
    task automatic spi_bits(input logic [7:0] val, input int nbits, input int half,
                            output logic [7:0] rm, output logic [7:0] rs, output logic [7:0] rw);
        rm = 8'hFF; rs = 8'hFF; rw = 8'hFF;
        for (int i = 7; i > 7 - nbits; i--) begin
            sck = 1'b0;
            sdi = val[i];
            repeat (half) @(negedge clk);
            rm[i] = m_sdo;
            rs[i] = s_sdo;
            rw[i] = w_sdo;
            sck = 1'b1;
            repeat (half) @(negedge clk);
        end
    endtask

    // Deselect while sck is still high so the trailing fall is ignored.
    task automatic end_txn();
        ss = 1'b1;
        repeat (4) @(negedge clk);
        sck = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    logic [7:0] rx_m[20], rx_s[20], rx_w[20];
    logic [7:0] dm, ds, dw;

    task automatic txn(input logic [7:0] cmd, input logic [7:0] pay, input int nbytes, input int half);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(cmd, 8, half, dm, ds, dw);
        for (int b = 0; b < nbytes; b++) spi_bits(pay, 8, half, rx_m[b], rx_s[b], rx_w[b]);
        end_txn();
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  pay;
        int          nbytes;
        logic        exp_up;
        logic [21:0] exp_addr;
        int          exp_rd;
        logic [21:0] exp_rd_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int base;

        vecs[0] = '{8'h56, 8'h01, 1, 1'b1, 22'd0, 1, 22'd0, 32'h0000_0000};
        vecs[1] = '{8'h57, 8'hFF, 4, 1'b1, 22'd4, 4, 22'd4, 32'hA5A4_A7A6};
        vecs[2] = '{8'h57, 8'hFF, 2, 1'b1, 22'd6, 2, 22'd6, 32'hA1A0_0000};
        vecs[3] = '{8'h56, 8'h00, 1, 1'b0, 22'd6, 0, 22'd0, 32'h0000_0000};
        vecs[4] = '{8'h57, 8'hFF, 2, 1'b0, 22'd6, 0, 22'd0, 32'hFFFF_0000};
        vecs[5] = '{8'h56, 8'h01, 1, 1'b1, 22'd0, 1, 22'd0, 32'h0000_0000};
        vecs[6] = '{8'h57, 8'h00, 1, 1'b1, 22'd1, 1, 22'd1, 32'hA500_0000};

        rst = 1'b1; ss = 1'b1; sck = 1'b0; sdi = 1'b0;
        repeat (3) @(negedge clk);
        check("reset sdo", m_sdo, 1);
        check("reset sdo_en", m_sdo_en, 0);
        check("reset uploading", m_up, 0);
        check("reset addr", m_addr, 0);
        check("reset rd", m_rd, 0);
        check("reset underrun", m_underrun, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Start/stop and streaming, sck = clk/8.
        foreach (vecs[v]) begin
            base = m_rd_total;
            txn(vecs[v].cmd, vecs[v].pay, vecs[v].nbytes, 4);
            check($sformatf("vec%0d uploading", v), m_up, vecs[v].exp_up);
            check($sformatf("vec%0d addr", v), m_addr, vecs[v].exp_addr);
            check($sformatf("vec%0d rd count", v), m_rd_total - base, vecs[v].exp_rd);
            check($sformatf("vec%0d underrun", v), m_underrun, 0);
            if (vecs[v].exp_rd > 0)
                check($sformatf("vec%0d rd addr", v), m_last_rd_addr, vecs[v].exp_rd_addr);
            if (vecs[v].cmd == 8'h57)
                for (int b = 0; b < vecs[v].nbytes; b++)
                    check($sformatf("vec%0d byte%0d", v, b), rx_m[b], vecs[v].exp_data[31-8*b -: 8]);
        end

        // Abort mid-byte, then resume with no rewind: addr=1 here, buf holds mem[1].
        ss = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(8'h57, 8, 4, dm, ds, dw);
        spi_bits(8'hFF, 8, 4, rx_m[0], rx_s[0], rx_w[0]);
        spi_bits(8'hFF, 3, 4, rx_m[1], rx_s[1], rx_w[1]);
        end_txn();
        check("abort byte0", rx_m[0], 8'hA4);
        check("abort addr", m_addr, 3);
        check("abort uploading", m_up, 1);
        txn(8'h57, 8'hFF, 1, 4);
        check("resume byte", rx_m[0], 8'hA6);
        check("resume addr", m_addr, 4);

        // Underrun with RD_LAT=32 at sck = clk/4.
        do_reset();
        txn(8'h56, 8'h01, 1, 2);
        txn(8'h57, 8'hFF, 3, 2);
        check("slow byte0", rx_s[0], 8'hA5);
        check("slow byte1", rx_s[1], 8'hFF);
        check("slow byte2", rx_s[2], 8'hFF);
        check("slow underrun", s_underrun, 1);
        check("fast no underrun", m_underrun, 0);
        txn(8'h57, 8'hFF, 1, 4);
        check("slow sticky underrun", s_underrun, 1);
        check("slow late byte", rx_s[0], 8'hA6);
        check("slow late addr", s_addr, 4);
        txn(8'h56, 8'h01, 1, 4);
        check("slow underrun cleared", s_underrun, 0);

        // Address wrap with aw=4.
        do_reset();
        txn(8'h56, 8'h01, 1, 4);
        txn(8'h57, 8'hFF, 18, 4);
        for (int b = 0; b < 18; b++)
            check($sformatf("wrap byte%0d", b), rx_w[b], mem_byte(b % 16));
        check("wrap seen", w_wrap_seen, 1);
        check("wrap addr", w_addr, 2);

        // Reset in the middle of a transfer (slow instance underruns first).
        ss = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(8'h57, 8, 2, dm, ds, dw);
        spi_bits(8'hFF, 8, 2, rx_m[0], rx_s[0], rx_w[0]);
        spi_bits(8'hFF, 3, 2, rx_m[1], rx_s[1], rx_w[1]);
        check("pre-reset sdo_en", m_sdo_en, 1);
        check("pre-reset slow underrun", s_underrun, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst sdo 1 cycle", m_sdo, 1);
        check("rst sdo_en 1 cycle", m_sdo_en, 0);
        repeat (2) @(negedge clk);
        check("rst uploading", m_up, 0);
        check("rst addr", m_addr, 0);
        check("rst rd", m_rd, 0);
        check("rst slow underrun", s_underrun, 0);
        check("rst slow uploading", s_up, 0);
        rst = 1'b0;
        ss  = 1'b1;
        repeat (4) @(negedge clk);
        sck = 1'b0;
        repeat (4) @(negedge clk);
        check("post-reset sdo", m_sdo, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
